// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit sides: FSM state encoding
// and default frame geometry.
package uart_pkg;

    localparam int unsigned DEF_DATA_BITS  = 8;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_os16_if.sv
// Byte-side ready/clear handshake of the 16x-oversampling UART receiver.
// Build option: UART_RX_PARITY_EN adds the parity_err flag.
interface uart_rx_os16_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = DEF_DATA_BITS
);

    logic [DATA_BITS-1:0] data;
    logic                 rdy;
    logic                 frame_err;
    logic                 overrun;
    logic                 rdy_clr;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    // master: the receiver that produces bytes; slave: the consumer of those bytes
    modport master (
        input  rdy_clr,
        output data, rdy, frame_err, overrun
`ifdef UART_RX_PARITY_EN
        , output parity_err
`endif
    );

    modport slave (
        output rdy_clr,
        input  data, rdy, frame_err, overrun
`ifdef UART_RX_PARITY_EN
        , input parity_err
`endif
    );

endinterface

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for an asynchronous input; flops reset to 1 so that
// idle-high lines do not glitch low out of reset.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// 16x-oversampling UART receiver: start-bit qualification, mid-bit data sampling,
// stop-bit check and a ready/clear byte handshake. Build option: UART_RX_PARITY_EN.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DEF_DATA_BITS,
    parameter int unsigned OVERSAMPLE  = DEF_OVERSAMPLE,
`ifdef UART_RX_PARITY_EN
    parameter bit          PARITY_ODD  = 1'b0,
`endif
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk_50m,
    input  logic           rst_n,
    input  logic           Rxclk_en,
    input  logic           rx,
    uart_rx_os16_if.master bus
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam uart_state_e AFTER_DATA = PARITY;
`else
    localparam uart_state_e AFTER_DATA = STOP;
`endif

    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 rxs;
`ifdef UART_RX_PARITY_EN
    logic                 par_q;
`endif

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_rx (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            bus.data      <= '0;
            bus.rdy       <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q          <= 1'b0;
            bus.parity_err <= 1'b0;
`endif
        end else begin
            // Consumer clear acts every cycle; a completing byte below overrides it.
            if (bus.rdy_clr) begin
                bus.rdy     <= 1'b0;
                bus.overrun <= 1'b0;
            end

            if (Rxclk_en) begin
                case (state_q)
                    IDLE: begin
                        if (!rxs) begin
                            state_q <= START;
                            cnt_q   <= '0;
                        end
                    end
                    START: begin
                        if (cnt_q == CNT_MID) begin
                            if (rxs) begin
                                state_q <= IDLE;
                            end else begin
                                state_q <= DATA;
                                cnt_q   <= '0;
                                bit_q   <= '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_q == CNT_END) begin
                            shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
                            cnt_q   <= '0;
                            bit_q   <= bit_q + BIT_W'(1);
                            if (bit_q == BIT_LAST) begin
                                state_q <= AFTER_DATA;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt_q == CNT_END) begin
                            par_q   <= rxs;
                            cnt_q   <= '0;
                            state_q <= STOP;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
`endif
                    STOP: begin
                        if (cnt_q == CNT_END) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            if (rxs) begin
                                bus.data      <= shift_q;
                                bus.rdy       <= 1'b1;
                                bus.frame_err <= 1'b0;
                                // A simultaneous clear means the old byte was consumed.
                                bus.overrun   <= bus.rdy & ~bus.rdy_clr;
`ifdef UART_RX_PARITY_EN
                                bus.parity_err <= ((^shift_q) ^ par_q) != PARITY_ODD;
`endif
                            end else begin
                                bus.frame_err <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
